// File: rtl/multicycle_controller_pkg.sv
// rtl/multicycle_controller_pkg.sv - shared opcodes, ALU codes, select encodings and FSM states
package multicycle_controller_pkg;

  localparam int WIDTH = 32;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_ADDI  = 6'b001000;

  localparam logic [5:0] FUNCT_ADD = 6'b100000;
  localparam logic [5:0] FUNCT_SUB = 6'b100010;
  localparam logic [5:0] FUNCT_AND = 6'b100100;
  localparam logic [5:0] FUNCT_OR  = 6'b100101;
  localparam logic [5:0] FUNCT_SLT = 6'b101010;

  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_SLT = 3'b111;

  localparam logic [2:0] SRCB_REGB  = 3'b000;
  localparam logic [2:0] SRCB_FOUR  = 3'b001;
  localparam logic [2:0] SRCB_INSTR = 3'b010;
  localparam logic [2:0] SRCB_SHIFT = 3'b011;
  localparam logic [2:0] SRCB_IMM   = 3'b100;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  typedef enum logic [3:0] {
    S_FETCH   = 4'd0,
    S_DECODE  = 4'd1,
    S_MEMADR  = 4'd2,
    S_MEMRD   = 4'd3,
    S_MEMWR   = 4'd4,
    S_RTYPEEX = 4'd5,
    S_RTYPEWB = 4'd6,
    S_BEQEX   = 4'd7,
    S_JEX     = 4'd8,
    S_ADDIEX  = 4'd9,
    S_ADDIWB  = 4'd10,
    S_BNEEX   = 4'd11
  } state_t;

  typedef enum logic [1:0] {
    ALUOP_ADD   = 2'b00,
    ALUOP_SUB   = 2'b01,
    ALUOP_FUNCT = 2'b10
  } aluop_t;

endpackage

// File: rtl/multicycle_controller_aludec.sv
// rtl/multicycle_controller_aludec.sv - ALU operation decode from op class and funct
module multicycle_controller_aludec
  import multicycle_controller_pkg::*;
(
  input  logic [1:0] aluop,
  input  logic [5:0] funct,
  output logic [2:0] alucont
);

  always_comb begin
    alucont = ALU_ADD;
    case (aluop)
      ALUOP_ADD: alucont = ALU_ADD;
      ALUOP_SUB: alucont = ALU_SUB;
      ALUOP_FUNCT: begin
        case (funct)
          FUNCT_ADD: alucont = ALU_ADD;
          FUNCT_SUB: alucont = ALU_SUB;
          FUNCT_AND: alucont = ALU_AND;
          FUNCT_OR:  alucont = ALU_OR;
          FUNCT_SLT: alucont = ALU_SLT;
          default:   alucont = ALU_ADD;
        endcase
      end
      default: alucont = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/multicycle_controller.sv
// rtl/multicycle_controller.sv - multicycle MIPS control FSM with memory-ready stalls; CTRL_BNE_EN adds bne
module multicycle_controller
  import multicycle_controller_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] op_i,
  input  logic [5:0] funct_i,
  input  logic       zero_i,
  input  logic       mem_ready_i,
  output logic       memread_o,
  output logic       memwrite_o,
  output logic       iord_o,
  output logic       irwrite_o,
  output logic       pcen_o,
  output logic [1:0] pcsource_o,
  output logic       alusrca_o,
  output logic [2:0] alusrcb_o,
  output logic [2:0] alucont_o,
  output logic       regwrite_o,
  output logic       regdst_o,
  output logic       memtoreg_o,
  output logic       illegal_o
);

  state_t     state, state_next;
  aluop_t     aluop;
  logic [2:0] alucont;
  logic       memread, memwrite, iord, irwrite, pcen, alusrca;
  logic       regwrite, regdst, memtoreg, illegal;
  logic [1:0] pcsource;
  logic [2:0] alusrcb;

  always_ff @(posedge clk) begin
    if (!rst) state <= S_FETCH;
    else      state <= state_next;
  end

  always_comb begin
    state_next = state;
    memread = 1'b0; memwrite = 1'b0; iord = 1'b0; irwrite = 1'b0;
    pcen = 1'b0; pcsource = PCSRC_ALU; alusrca = 1'b0; alusrcb = SRCB_REGB;
    aluop = ALUOP_ADD; regwrite = 1'b0; regdst = 1'b0; memtoreg = 1'b0;
    illegal = 1'b0;
    case (state)
      S_FETCH: begin
        memread = 1'b1;
        alusrcb = SRCB_FOUR;
        irwrite = mem_ready_i;
        pcen    = mem_ready_i;
        if (mem_ready_i) state_next = S_DECODE;
      end
      S_DECODE: begin
        alusrcb = SRCB_SHIFT;
        case (op_i)
          OP_LW, OP_SW: state_next = S_MEMADR;
          OP_RTYPE:     state_next = S_RTYPEEX;
          OP_BEQ:       state_next = S_BEQEX;
          OP_J:         state_next = S_JEX;
          OP_ADDI:      state_next = S_ADDIEX;
`ifdef CTRL_BNE_EN
          OP_BNE:       state_next = S_BNEEX;
`endif
          default: begin
            state_next = S_FETCH;
            illegal    = 1'b1;
          end
        endcase
      end
      S_MEMADR: begin
        alusrca = 1'b1;
        alusrcb = SRCB_IMM;
        state_next = (op_i == OP_LW) ? S_MEMRD : S_MEMWR;
      end
      // ALU selects held at MEMADR values so ALU-out keeps the address.
      S_MEMRD: begin
        alusrca  = 1'b1;
        alusrcb  = SRCB_IMM;
        memread  = 1'b1;
        iord     = 1'b1;
        memtoreg = 1'b1;
        regwrite = mem_ready_i;
        if (mem_ready_i) state_next = S_FETCH;
      end
      S_MEMWR: begin
        alusrca  = 1'b1;
        alusrcb  = SRCB_IMM;
        memwrite = 1'b1;
        iord     = 1'b1;
        if (mem_ready_i) state_next = S_FETCH;
      end
      S_RTYPEEX: begin
        alusrca = 1'b1;
        alusrcb = SRCB_REGB;
        aluop   = ALUOP_FUNCT;
        state_next = S_RTYPEWB;
      end
      S_RTYPEWB: begin
        regdst   = 1'b1;
        regwrite = 1'b1;
        state_next = S_FETCH;
      end
      S_ADDIEX: begin
        alusrca = 1'b1;
        alusrcb = SRCB_IMM;
        state_next = S_ADDIWB;
      end
      S_ADDIWB: begin
        regwrite = 1'b1;
        state_next = S_FETCH;
      end
      S_BEQEX: begin
        alusrca  = 1'b1;
        alusrcb  = SRCB_REGB;
        aluop    = ALUOP_SUB;
        pcsource = PCSRC_ALUOUT;
        pcen     = zero_i;
        state_next = S_FETCH;
      end
`ifdef CTRL_BNE_EN
      S_BNEEX: begin
        alusrca  = 1'b1;
        alusrcb  = SRCB_REGB;
        aluop    = ALUOP_SUB;
        pcsource = PCSRC_ALUOUT;
        pcen     = ~zero_i;
        state_next = S_FETCH;
      end
`endif
      S_JEX: begin
        pcsource = PCSRC_JUMP;
        pcen     = 1'b1;
        state_next = S_FETCH;
      end
      default: state_next = S_FETCH;
    endcase
  end

  multicycle_controller_aludec u_aludec (
    .aluop   (aluop),
    .funct   (funct_i),
    .alucont (alucont)
  );

  // Reset gates every output so no strobe or enable can fire while held.
  assign memread_o  = rst & memread;
  assign memwrite_o = rst & memwrite;
  assign iord_o     = rst & iord;
  assign irwrite_o  = rst & irwrite;
  assign pcen_o     = rst & pcen;
  assign pcsource_o = rst ? pcsource : 2'b00;
  assign alusrca_o  = rst & alusrca;
  assign alusrcb_o  = rst ? alusrcb : 3'b000;
  assign alucont_o  = rst ? alucont : 3'b000;
  assign regwrite_o = rst & regwrite;
  assign regdst_o   = rst & regdst;
  assign memtoreg_o = rst & memtoreg;
  assign illegal_o  = rst & illegal;

endmodule

// File: tb/tb_multicycle_controller.sv
// tb/tb_multicycle_controller.sv - table-driven per-cycle check of multicycle_controller outputs
module tb_multicycle_controller;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [5:0] op_i = 6'd0, funct_i = 6'd0;
  logic       zero_i = 1'b0, mem_ready_i = 1'b1;
  logic       memread_o, memwrite_o, iord_o, irwrite_o, pcen_o;
  logic [1:0] pcsource_o;
  logic       alusrca_o;
  logic [2:0] alusrcb_o, alucont_o;
  logic       regwrite_o, regdst_o, memtoreg_o, illegal_o;

  int n_cmp = 0;
  int n_bad = 0;

  multicycle_controller dut (
    .clk(clk), .rst(rst), .op_i(op_i), .funct_i(funct_i), .zero_i(zero_i),
    .mem_ready_i(mem_ready_i), .memread_o(memread_o), .memwrite_o(memwrite_o),
    .iord_o(iord_o), .irwrite_o(irwrite_o), .pcen_o(pcen_o), .pcsource_o(pcsource_o),
    .alusrca_o(alusrca_o), .alusrcb_o(alusrcb_o), .alucont_o(alucont_o),
    .regwrite_o(regwrite_o), .regdst_o(regdst_o), .memtoreg_o(memtoreg_o),
    .illegal_o(illegal_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic [5:0]  op;
    logic [5:0]  funct;
    logic        zero;
    logic        ready;
    logic [17:0] exp;
  } vec_t;

  vec_t tbl[$];

  // {memread,memwrite,iord,irwrite,pcen,pcsource,alusrca,alusrcb,alucont,regwrite,regdst,memtoreg,illegal}
  function automatic logic [17:0] o(input logic mr, mw, io, irw, pce, input logic [1:0] pcs,
                                     input logic asa, input logic [2:0] asb, ac,
                                     input logic rw, rd, m2r, ill);
    return {mr, mw, io, irw, pce, pcs, asa, asb, ac, rw, rd, m2r, ill};
  endfunction

  function automatic vec_t v(input logic r, input logic [5:0] op, fn, input logic z, rdy,
                             input logic [17:0] e);
    vec_t t;
    t.rst = r; t.op = op; t.funct = fn; t.zero = z; t.ready = rdy; t.exp = e;
    return t;
  endfunction

  task automatic apply(input vec_t t, input int idx);
    logic [17:0] act;
    @(negedge clk);
    rst = t.rst; op_i = t.op; funct_i = t.funct; zero_i = t.zero; mem_ready_i = t.ready;
    #1;
    act = {memread_o, memwrite_o, iord_o, irwrite_o, pcen_o, pcsource_o, alusrca_o,
           alusrcb_o, alucont_o, regwrite_o, regdst_o, memtoreg_o, illegal_o};
    n_cmp++;
    if (act !== t.exp) begin
      n_bad++;
      $display("FAIL step%0d op=%b: outputs got %b want %b", idx, t.op, act, t.exp);
    end
  endtask

  localparam logic [5:0] RT = 6'b000000, LW = 6'b100011, SW = 6'b101011, BEQ = 6'b000100;
  localparam logic [5:0] BNE = 6'b000101, JJ = 6'b000010, ADDI = 6'b001000, BAD = 6'b111111;

  logic [17:0] Z, F1, F0, DEC, DECI, MA, MRS, MRR, MW, RW, AI, AW, JX;

  initial begin
    Z    = '0;
    F1   = o(1,0,0,1,1,2'b00,0,3'b001,3'b010,0,0,0,0);
    F0   = o(1,0,0,0,0,2'b00,0,3'b001,3'b010,0,0,0,0);
    DEC  = o(0,0,0,0,0,2'b00,0,3'b011,3'b010,0,0,0,0);
    DECI = o(0,0,0,0,0,2'b00,0,3'b011,3'b010,0,0,0,1);
    MA   = o(0,0,0,0,0,2'b00,1,3'b100,3'b010,0,0,0,0);
    MRS  = o(1,0,1,0,0,2'b00,1,3'b100,3'b010,0,0,1,0);
    MRR  = o(1,0,1,0,0,2'b00,1,3'b100,3'b010,1,0,1,0);
    MW   = o(0,1,1,0,0,2'b00,1,3'b100,3'b010,0,0,0,0);
    RW   = o(0,0,0,0,0,2'b00,0,3'b000,3'b010,1,1,0,0);
    AI   = o(0,0,0,0,0,2'b00,1,3'b100,3'b010,0,0,0,0);
    AW   = o(0,0,0,0,0,2'b00,0,3'b000,3'b010,1,0,0,0);
    JX   = o(0,0,0,0,1,2'b10,0,3'b000,3'b010,0,0,0,0);

    for (int i = 0; i < 3; i++) tbl.push_back(v(0, RT, 6'b100000, 0, 1, Z));
    // R-type add and sub
    tbl.push_back(v(1, RT, 6'b100000, 0, 1, F1));
    tbl.push_back(v(1, RT, 6'b100000, 0, 1, DEC));
    tbl.push_back(v(1, RT, 6'b100000, 0, 1, o(0,0,0,0,0,2'b00,1,3'b000,3'b010,0,0,0,0)));
    tbl.push_back(v(1, RT, 6'b100000, 0, 1, RW));
    tbl.push_back(v(1, RT, 6'b100010, 0, 1, F1));
    tbl.push_back(v(1, RT, 6'b100010, 0, 1, DEC));
    tbl.push_back(v(1, RT, 6'b100010, 0, 1, o(0,0,0,0,0,2'b00,1,3'b000,3'b110,0,0,0,0)));
    tbl.push_back(v(1, RT, 6'b100010, 0, 1, RW));
    // lw with two wait states in MEMRD
    tbl.push_back(v(1, LW, 6'd0, 0, 1, F1));
    tbl.push_back(v(1, LW, 6'd0, 0, 1, DEC));
    tbl.push_back(v(1, LW, 6'd0, 0, 1, MA));
    tbl.push_back(v(1, LW, 6'd0, 0, 0, MRS));
    tbl.push_back(v(1, LW, 6'd0, 0, 0, MRS));
    tbl.push_back(v(1, LW, 6'd0, 0, 1, MRR));
    // fetch stall then beq taken / not taken
    tbl.push_back(v(1, BEQ, 6'd0, 0, 0, F0));
    tbl.push_back(v(1, BEQ, 6'd0, 0, 1, F1));
    tbl.push_back(v(1, BEQ, 6'd0, 0, 1, DEC));
    tbl.push_back(v(1, BEQ, 6'd0, 1, 1, o(0,0,0,0,1,2'b01,1,3'b000,3'b110,0,0,0,0)));
    tbl.push_back(v(1, BEQ, 6'd0, 0, 1, F1));
    tbl.push_back(v(1, BEQ, 6'd0, 0, 1, DEC));
    tbl.push_back(v(1, BEQ, 6'd0, 0, 1, o(0,0,0,0,0,2'b01,1,3'b000,3'b110,0,0,0,0)));
    // illegal opcode, then bne
    tbl.push_back(v(1, BAD, 6'd0, 0, 1, F1));
    tbl.push_back(v(1, BAD, 6'd0, 0, 1, DECI));
    tbl.push_back(v(1, BNE, 6'd0, 0, 1, F1));
`ifdef CTRL_BNE_EN
    tbl.push_back(v(1, BNE, 6'd0, 0, 1, DEC));
    tbl.push_back(v(1, BNE, 6'd0, 0, 1, o(0,0,0,0,1,2'b01,1,3'b000,3'b110,0,0,0,0)));
    tbl.push_back(v(1, ADDI, 6'd0, 0, 1, F1));
`else
    tbl.push_back(v(1, BNE, 6'd0, 0, 1, DECI));
    tbl.push_back(v(1, BNE, 6'd0, 0, 1, F1));
    tbl.push_back(v(1, ADDI, 6'd0, 0, 1, DEC));
`endif
    tbl.push_back(v(0, ADDI, 6'd0, 0, 1, Z));
    // addi, j
    tbl.push_back(v(1, ADDI, 6'd0, 0, 1, F1));
    tbl.push_back(v(1, ADDI, 6'd0, 0, 1, DEC));
    tbl.push_back(v(1, ADDI, 6'd0, 0, 1, AI));
    tbl.push_back(v(1, ADDI, 6'd0, 0, 1, AW));
    tbl.push_back(v(1, JJ, 6'd0, 0, 1, F1));
    tbl.push_back(v(1, JJ, 6'd0, 0, 1, DEC));
    tbl.push_back(v(1, JJ, 6'd0, 0, 1, JX));
    // remaining funct codes, including an unknown one that falls back to add
    tbl.push_back(v(1, RT, 6'b100101, 0, 1, F1));
    tbl.push_back(v(1, RT, 6'b100101, 0, 1, DEC));
    tbl.push_back(v(1, RT, 6'b100101, 0, 1, o(0,0,0,0,0,2'b00,1,3'b000,3'b001,0,0,0,0)));
    tbl.push_back(v(1, RT, 6'b100101, 0, 1, RW));
    tbl.push_back(v(1, RT, 6'b101010, 0, 1, F1));
    tbl.push_back(v(1, RT, 6'b101010, 0, 1, DEC));
    tbl.push_back(v(1, RT, 6'b101010, 0, 1, o(0,0,0,0,0,2'b00,1,3'b000,3'b111,0,0,0,0)));
    tbl.push_back(v(1, RT, 6'b101010, 0, 1, RW));
    tbl.push_back(v(1, RT, 6'b100100, 0, 1, F1));
    tbl.push_back(v(1, RT, 6'b100100, 0, 1, DEC));
    tbl.push_back(v(1, RT, 6'b100100, 0, 1, o(0,0,0,0,0,2'b00,1,3'b000,3'b000,0,0,0,0)));
    tbl.push_back(v(1, RT, 6'b100100, 0, 1, RW));
    tbl.push_back(v(1, RT, 6'b000111, 0, 1, F1));
    tbl.push_back(v(1, RT, 6'b000111, 0, 1, DEC));
    tbl.push_back(v(1, RT, 6'b000111, 0, 1, o(0,0,0,0,0,2'b00,1,3'b000,3'b010,0,0,0,0)));
    tbl.push_back(v(1, RT, 6'b000111, 0, 1, RW));
    // sw with zero wait states
    tbl.push_back(v(1, SW, 6'd0, 0, 1, F1));
    tbl.push_back(v(1, SW, 6'd0, 0, 1, DEC));
    tbl.push_back(v(1, SW, 6'd0, 0, 1, MA));
    tbl.push_back(v(1, SW, 6'd0, 0, 1, MW));

    foreach (tbl[i]) apply(tbl[i], i);

    // reset during a stalled MEMWR: strobe drops at once, FSM restarts in FETCH
    apply(v(1, SW, 6'd0, 0, 1, F1), 100);
    apply(v(1, SW, 6'd0, 0, 1, DEC), 101);
    apply(v(1, SW, 6'd0, 0, 1, MA), 102);
    apply(v(1, SW, 6'd0, 0, 0, MW), 103);
    apply(v(1, SW, 6'd0, 0, 0, MW), 104);
    apply(v(0, SW, 6'd0, 0, 0, Z), 105);
    apply(v(1, SW, 6'd0, 0, 0, F0), 106);
    apply(v(1, SW, 6'd0, 0, 1, F1), 107);
    apply(v(1, SW, 6'd0, 0, 1, DEC), 108);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/multicycle_controller.md
# multicycle_controller

Control unit for the multicycle 32-bit MIPS datapath. It decodes the fetched instruction's opcode and funct fields and sequences the datapath's mux selects, register and IR write enables, PC enable and ALU operation, one state per clock. It also drives the memory strobes and stalls on a memory-ready handshake. It sits beside the datapath: it consumes the datapath's instruction and zero flag and produces every control input of the datapath.

## Interface
Parameters:
- none; widths come from shared constants (`WIDTH` = 32).

Ports:
- clk  input  1  system clock; all state updates on the rising edge
- rst  input  1  reset, synchronous, active-low
- op_i  input  6  instruction bits [31:26] from the IR
- funct_i  input  6  instruction bits [5:0] from the IR
- zero_i  input  1  datapath ALU-result-is-zero flag
- mem_ready_i  input  1  memory has completed the current access this cycle
- memread_o  output  1  memory read strobe
- memwrite_o  output  1  memory write strobe
- iord_o  output  1  memory address select: 0 = PC, 1 = ALU-out
- irwrite_o  output  1  IR load enable
- pcen_o  output  1  PC load enable
- pcsource_o  output  2  next-PC select: 00 = ALU result, 01 = ALU-out, 10 = jump target, 11 = zero
- alusrca_o  output  1  ALU A select: 0 = PC, 1 = reg A
- alusrcb_o  output  3  ALU B select: 000 = reg B, 001 = 4, 010 = instruction, 011 = shifted instruction, 100 = sign-extended imm
- alucont_o  output  3  ALU operation
- regwrite_o  output  1  register-file write enable
- regdst_o  output  1  write address select: 0 = rt, 1 = rd
- memtoreg_o  output  1  write data select: 0 = ALU-out, 1 = memory read data
- illegal_o  output  1  one-cycle pulse on an unsupported opcode

## Operation
- Moore FSM. All outputs decode from the state, except the handshake-qualified enables listed below.
- States and transitions:
  - FETCH -> DECODE when mem_ready_i = 1; otherwise hold.
  - DECODE -> MEMADR for lw (100011) and sw (101011).
  - DECODE -> RTYPEEX for opcode 000000.
  - DECODE -> BEQEX for beq (000100).
  - DECODE -> JEX for j (000010).
  - DECODE -> ADDIEX for addi (001000).
  - DECODE -> FETCH for any other opcode, with illegal_o = 1.
  - MEMADR -> MEMRD for lw; MEMADR -> MEMWR for sw.
  - MEMRD and MEMWR -> FETCH when mem_ready_i = 1; otherwise hold.
  - RTYPEEX -> RTYPEWB -> FETCH.
  - ADDIEX -> ADDIWB -> FETCH.
  - BEQEX -> FETCH; JEX -> FETCH.
- Signals not listed for a state are 0.
  - FETCH: memread = 1, iord = 0, alusrca = 0, alusrcb = 001, alucont = add. irwrite and pcen equal mem_ready_i, so the PC advances by 4 only once.
  - DECODE: alusrca = 0, alusrcb = 011, alucont = add. This computes the branch target into ALU-out.
  - MEMADR: alusrca = 1, alusrcb = 100, alucont = add.
  - MEMRD: memread = 1, iord = 1, memtoreg = 1, regdst = 0, regwrite = mem_ready_i. The ALU selects stay at the MEMADR values so ALU-out is held stable. There is no MDR: write-back happens in the same cycle the data is valid.
  - MEMWR: memwrite = 1, iord = 1. The ALU selects stay at the MEMADR values.
  - RTYPEEX: alusrca = 1, alusrcb = 000, alucont decoded from funct.
  - RTYPEWB: regdst = 1, regwrite = 1, memtoreg = 0.
  - ADDIEX: alusrca = 1, alusrcb = 100, alucont = add.
  - ADDIWB: regdst = 0, regwrite = 1.
  - BEQEX: alusrca = 1, alusrcb = 000, alucont = sub, pcsource = 01, pcen = zero_i.
  - JEX: pcsource = 10, pcen = 1.
- ALU operation codes: add = 010, sub = 110, and = 000, or = 001, slt = 111.
- funct decode: 100000 -> add, 100010 -> sub, 100100 -> and, 100101 -> or, 101010 -> slt. Any other funct -> add.

## Timing
- State register is synchronous. While rst = 0, every output is forced to 0; this covers memread, memwrite, regwrite, irwrite and pcen.
- The first edge with rst = 1 sees state FETCH.
- Reset asserted in any state, including a stalled MEMRD or MEMWR, returns the FSM to FETCH at the next edge. No write strobe fires while rst = 0.
- Cycles per instruction with zero wait states:
  - lw, sw, R-type, addi: 4
  - beq, j: 3
  - Each cycle that mem_ready_i is low in FETCH, MEMRD or MEMWR adds one cycle.
- mem_ready_i is sampled combinationally in the same cycle. The memory may hold it high continuously to model zero-wait memory.
- illegal_o is high for exactly the DECODE cycle of an unsupported opcode.

## Configuration
- CTRL_BNE_EN:
  - Defined: opcode 000101 (bne) decodes to state BNEEX. BNEEX drives the same outputs as BEQEX except pcen = ~zero_i, then goes to FETCH.
  - Undefined: 000101 is unsupported. It returns to FETCH with illegal_o pulsed.

## Structure
- Shared defines file holds:
  - opcode constants (OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_BNE, OP_J, OP_ADDI)
  - funct constants
  - ALU operation codes
  - alusrcb and pcsource encodings
  - 4-bit state encodings
- One sub-module, ALUDEC: combinational funct plus a 2-bit ALU-op class (add / sub / funct) -> alucont_o. It is instantiated once.

## Test plan
- Reset: rst = 0 for 3 cycles with mem_ready_i = 1 -> all outputs 0. First cycle after release is FETCH with memread = 1, irwrite = 1, pcen = 1, alusrcb = 001.
- R-type add: op = 000000, funct = 100000, ready held high -> RTYPEEX has alucont = 010, alusrcb = 000. RTYPEWB has regwrite = 1, regdst = 1. Back in FETCH after 4 cycles.
- lw with 2 wait states: mem_ready_i low for 2 cycles in MEMRD -> regwrite stays 0, then pulses exactly once with memtoreg = 1 on the ready cycle. Total 6 cycles.
- beq: zero_i = 1 -> pcen = 1 with pcsource = 01 in BEQEX. zero_i = 0 -> pcen = 0. Both take 3 cycles.
- Illegal opcode 111111 -> illegal_o pulses for 1 cycle in DECODE, then FETCH. With CTRL_BNE_EN, opcode 000101 with zero_i = 0 -> pcen = 1, and illegal_o stays 0.
- Reset mid-MEMWR stall: rst = 0 while memwrite = 1 -> memwrite drops in the same cycle, and the state is FETCH after release.
